// File: rtl/sm_ctrl_pkg.sv
// Shared definitions for the control-FSM sequencer: observed codes, controller
// state encoding and the per-step drive/park/expect table.
package sm_ctrl_pkg;

  localparam logic [2:0] OBS_IDLE = 3'b000;
  localparam logic [2:0] OBS_S1   = 3'b100;
  localparam logic [2:0] OBS_S2   = 3'b010;
  localparam logic [2:0] OBS_ERR  = 3'b111;

  typedef enum logic [2:0] {
    C_IDLE    = 3'd0,
    C_DRIVE   = 3'd1,
    C_CHECK   = 3'd2,
    C_RECOVER = 3'd3,
    C_RCHK    = 3'd4
  } cstate_t;

  // drive/park are {i1,i2}
  typedef struct packed {
    logic [1:0] drive;
    logic [1:0] park;
    logic [2:0] exp_obs;
  } step_t;

  function automatic step_t step_info(input logic [1:0] idx);
    step_t s;
    case (idx)
      2'd0:    s = '{drive: 2'b11, park: 2'b00, exp_obs: OBS_S1};
      2'd1:    s = '{drive: 2'b11, park: 2'b01, exp_obs: OBS_S2};
      2'd2:    s = '{drive: 2'b10, park: 2'b00, exp_obs: OBS_IDLE};
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sm_seq_ctrl_if.sv
// Host/FSM-side bundle of the sequencer: run request, status and the FSM
// observe/drive pair.
interface sm_seq_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] loops;
  logic             force_err;
  logic [2:0]       obs;
  logic             i1;
  logic             i2;
  logic             busy;
  logic             done;
  logic             fail;
  logic [CNT_W-1:0] loops_done;
  logic [3:0]       retries;

  modport master (
    output start, loops, force_err, obs,
    input  i1, i2, busy, done, fail, loops_done, retries
  );

  modport slave (
    input  start, loops, force_err, obs,
    output i1, i2, busy, done, fail, loops_done, retries
  );
endinterface

// File: rtl/sm_seq_ctrl.sv
// Walks the control FSM through IDLE->S1->S2->IDLE loops, checks its registered
// outputs after every step and recovers from ERROR a bounded number of times.
module sm_seq_ctrl
  import sm_ctrl_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MAX_RETRY = 2
) (
  input logic          clk,
  input logic          nrst,
  sm_seq_ctrl_if.slave bus
);

  cstate_t          state, state_d;
  logic [1:0]       step, step_d;
  logic [1:0]       drv, drv_d;
  logic             busy, busy_d, done, done_d, fail, fail_d;
  logic [CNT_W-1:0] loops_q, loops_d, ld, ld_d;
  logic [3:0]       rt, rt_d;
  step_t            cur;
  logic             match, can_retry, last_loop;

  assign cur       = step_info(step);
  assign match     = (bus.obs == cur.exp_obs);
  assign can_retry = (bus.obs == OBS_ERR) && (rt < 4'(MAX_RETRY));
  assign last_loop = (step == 2'd2) && (CNT_W'(ld + 1'b1) == loops_q);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= C_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      C_IDLE:    if (bus.start) state_d = C_DRIVE;
      C_DRIVE:   state_d = (loops_q == '0) ? C_IDLE : C_CHECK;
      C_CHECK: begin
        if (!match)         state_d = can_retry ? C_RECOVER : C_IDLE;
        else if (last_loop) state_d = C_IDLE;
        else                state_d = C_DRIVE;
      end
      C_RECOVER: state_d = C_RCHK;
      C_RCHK:    state_d = (bus.obs == OBS_IDLE) ? C_DRIVE : C_IDLE;
      default:   state_d = C_IDLE;
    endcase
  end

  // Next values of the registered outputs; drv_d defaults to the (0,0) park.
  always_comb begin
    drv_d   = 2'b00;
    busy_d  = busy;
    done_d  = 1'b0;
    fail_d  = fail;
    step_d  = step;
    ld_d    = ld;
    rt_d    = rt;
    loops_d = loops_q;
    case (state)
      C_IDLE: if (bus.start) begin
        busy_d  = 1'b1;
        fail_d  = 1'b0;
        ld_d    = '0;
        rt_d    = '0;
        step_d  = 2'd0;
        loops_d = bus.loops;
        // a forced run substitutes (1,0) on its very first drive only
        if (bus.loops != '0) drv_d = bus.force_err ? 2'b10 : step_info(2'd0).drive;
      end
      C_DRIVE: begin
        if (loops_q == '0) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          drv_d = cur.park;
        end
      end
      C_CHECK: begin
        if (match) begin
          if (step == 2'd2) ld_d = ld + 1'b1;
          if (last_loop) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            step_d = (step == 2'd2) ? 2'd0 : step + 2'd1;
            drv_d  = step_info(step_d).drive;
          end
        end else if (can_retry) begin
          rt_d   = rt + 4'd1;
          step_d = 2'd0;
        end else begin
          busy_d = 1'b0;
          done_d = 1'b1;
          fail_d = 1'b1;
        end
      end
      C_RECOVER: drv_d = 2'b00;
      C_RCHK: begin
        if (bus.obs == OBS_IDLE) begin
          drv_d = step_info(2'd0).drive;
        end else begin
          busy_d = 1'b0;
          done_d = 1'b1;
          fail_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      drv     <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
      step    <= 2'd0;
      ld      <= '0;
      rt      <= '0;
      loops_q <= '0;
    end else begin
      drv     <= drv_d;
      busy    <= busy_d;
      done    <= done_d;
      fail    <= fail_d;
      step    <= step_d;
      ld      <= ld_d;
      rt      <= rt_d;
      loops_q <= loops_d;
    end
  end

  assign bus.i1         = drv[1];
  assign bus.i2         = drv[0];
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.fail       = fail;
  assign bus.loops_done = ld;
  assign bus.retries    = rt;

endmodule

// File: tb/tb_sm_seq_ctrl.sv
// Bench for sm_seq_ctrl: behavioural control FSM with fault injection, and a
// step-level run predictor giving end edge, fail and counters.
module tb_sm_seq_ctrl;

  localparam logic [2:0] S_IDLE = 3'b000, S_S1 = 3'b100, S_S2 = 3'b010, S_ERR = 3'b111;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  sm_seq_ctrl_if #(.CNT_W(8)) bi ();
  sm_seq_ctrl_if #(.CNT_W(8)) bz ();

  sm_seq_ctrl #(.CNT_W(8), .MAX_RETRY(2)) dut  (.clk(clk), .nrst(nrst), .bus(bi));
  sm_seq_ctrl #(.CNT_W(8), .MAX_RETRY(0)) dut0 (.clk(clk), .nrst(nrst), .bus(bz));

  logic [2:0]  fsm_a, fsm_b, ovr_val;
  logic        ovr;
  logic [5:0]  att;
  logic [31:0] errmask;
  int          n_chk = 0, n_pass = 0;

  assign bi.obs = ovr ? ovr_val : fsm_a;
  assign bz.obs = fsm_b;

  function automatic logic [2:0] fsm_nx(input logic [2:0] c, input logic a, input logic b);
    case (c)
      S_IDLE:  return (a && b) ? S_S1 : (a && !b) ? S_ERR : S_IDLE;
      S_S1:    return (a && b) ? S_S2 : (!a && !b) ? S_S1 : S_ERR;
      S_S2:    return (a && !b) ? S_IDLE : (!a && b) ? S_S2 : S_ERR;
      default: return (!a && !b) ? S_IDLE : S_ERR;
    endcase
  endfunction

  // errmask bit k sends the FSM to ERROR on the k-th drive (i1=1) of a run
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fsm_a <= S_IDLE;
      att   <= '0;
    end else begin
      if (bi.start && !bi.busy) att <= '0;
      else if (bi.i1)           att <= att + 6'd1;
      fsm_a <= (bi.i1 && errmask[att[4:0]]) ? S_ERR : fsm_nx(fsm_a, bi.i1, bi.i2);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) fsm_b <= S_IDLE;
    else       fsm_b <= fsm_nx(fsm_b, bz.i1, bz.i2);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Step-level model: each step or recovery costs 2 edges; recovery restarts the loop.
  function automatic void predict(input int nl, input bit fe, input logic [31:0] m, input int maxr,
                                  output int e_end, output bit e_fail, output int e_ld, output int e_rt);
    int a, st;
    bit err;
    e_end = 0; e_fail = 0; e_ld = 0; e_rt = 0; a = 0; st = 0;
    if (nl == 0) begin
      e_end = 1;
      return;
    end
    for (int k = 0; k < 1000; k++) begin
      err = (a == 0 && fe) || m[a % 32];
      a++;
      e_end += 2;
      if (err) begin
        if (e_rt < maxr) begin
          e_rt++;
          e_end += 2;
          st = 0;
        end else begin
          e_fail = 1;
          return;
        end
      end else if (st == 2) begin
        e_ld++;
        st = 0;
        if (e_ld == nl) return;
      end else begin
        st++;
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk); nrst = 1'b0;
    @(negedge clk); @(negedge clk); nrst = 1'b1;
  endtask

  task automatic run(input int nl, input bit fe, input logic [31:0] m, input int poke, input string tag);
    int e_end, e_ld, e_rt, n;
    bit e_fail, bad_busy, drv_seen;
    predict(nl, fe, m, 2, e_end, e_fail, e_ld, e_rt);
    do_reset();
    errmask = m;
    @(negedge clk); bi.start = 1'b1; bi.loops = 8'(nl); bi.force_err = fe;
    @(posedge clk);
    @(negedge clk); bi.start = 1'b0;
    n = 0; bad_busy = 0; drv_seen = 0;
    while (!bi.done && n < 2000) begin
      if (!bi.busy) bad_busy = 1;
      if (bi.i1 || bi.i2) drv_seen = 1;
      bi.start = (n == poke);
      bi.loops = 8'd1;
      @(posedge clk); n++; @(negedge clk);
    end
    bi.start = 1'b0;
    chk({tag, " end_edge"}, n, e_end);
    chk({tag, " done"}, bi.done, 1);
    chk({tag, " fail"}, bi.fail, e_fail);
    chk({tag, " loops_done"}, bi.loops_done, e_ld);
    chk({tag, " retries"}, bi.retries, e_rt);
    chk({tag, " busy_end"}, bi.busy, 0);
    chk({tag, " busy_run"}, bad_busy, 0);
    chk({tag, " i1i2_end"}, {bi.i1, bi.i2}, 0);
    if (nl == 0) chk({tag, " no_drive"}, drv_seen, 0);
    @(negedge clk);
    chk({tag, " done_pulse"}, bi.done, 0);
  endtask

  initial begin
    int n;
    bit flag;
    logic [31:0] m;
    bi.start = 0; bi.loops = 0; bi.force_err = 0;
    bz.start = 0; bz.loops = 0; bz.force_err = 0;
    ovr = 0; ovr_val = 3'b000; errmask = '0;

    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("reset outs", {bi.i1, bi.i2, bi.busy, bi.done, bi.fail}, 0);
    chk("reset counters", {bi.loops_done, bi.retries}, 0);

    run(3, 0, 32'h0, -1, "clean3");
    run(1, 1, 32'h0, -1, "force1");
    run(0, 0, 32'h0, -1, "zero");
    run(4, 0, 32'h0, 5, "ignore_start");
    run(2, 0, 32'h4, -1, "glitch");
    run(1, 0, 32'h7, -1, "exhaust");

    // MAX_RETRY=0 instance: the forced error is immediately fatal
    do_reset();
    @(negedge clk); bz.start = 1; bz.loops = 8'd2; bz.force_err = 1;
    @(posedge clk);
    @(negedge clk); bz.start = 0;
    n = 0;
    while (!bz.done && n < 100) begin
      @(posedge clk); n++; @(negedge clk);
    end
    chk("mr0 end_edge", n, 2);
    chk("mr0 fail", bz.fail, 1);
    chk("mr0 counters", {bz.loops_done, bz.retries}, 0);
    @(negedge clk);
    chk("mr0 i1i2_after", {bz.i1, bz.i2}, 0);
    chk("mr0 busy_after", bz.busy, 0);

    // obs stuck at IDLE: mismatch on the first check
    do_reset();
    errmask = '0; ovr = 1; ovr_val = 3'b000;
    @(negedge clk); bi.start = 1; bi.loops = 8'd1; bi.force_err = 0;
    @(posedge clk);
    @(negedge clk); bi.start = 0;
    n = 0;
    while (!bi.done && n < 100) begin
      @(posedge clk); n++; @(negedge clk);
    end
    chk("stuck end_edge", n, 2);
    chk("stuck fail", bi.fail, 1);
    ovr = 0;
    bi.start = 1;
    @(posedge clk);
    @(negedge clk); bi.start = 0;
    chk("restart clears fail", bi.fail, 0);
    chk("restart busy", bi.busy, 1);

    // reset in the middle of a 5-loop run
    do_reset();
    @(negedge clk); bi.start = 1; bi.loops = 8'd5; bi.force_err = 0;
    @(posedge clk);
    #1 bi.start = 0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst loops_done", bi.loops_done, 1);
    nrst = 1'b0;
    #1;
    chk("midrst outs", {bi.i1, bi.i2, bi.busy, bi.done, bi.fail}, 0);
    chk("midrst counters", {bi.loops_done, bi.retries}, 0);
    flag = 0;
    repeat (2) begin
      @(negedge clk); if (bi.done) flag = 1;
    end
    nrst = 1'b1;
    repeat (10) begin
      @(negedge clk); if (bi.done || bi.busy) flag = 1;
    end
    chk("midrst no_done", flag, 0);
    run(2, 0, 32'h0, -1, "post_rst");

    for (int r = 0; r < 12; r++) begin
      m = '0;
      for (int b = 0; b < 24; b++) if ($urandom_range(0, 5) == 0) m[b] = 1'b1;
      run(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), m, -1, $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sm_seq_ctrl.md
# sm_seq_ctrl

Sequencing controller for the three-state control FSM (observed outputs `o1`/`o2`/`err`). On a start request it drives the FSM's `i1`/`i2` inputs through a programmable number of IDLE→S1→S2→IDLE loops. It checks the FSM's registered outputs after every step and recovers from the ERROR state with a bounded retry count. It sits between the test/config host and the FSM instance, and is the FSM's only input driver.

## Interface
- `CNT_W`, 8: width of the loop count and the `loops_done` counter.
- `MAX_RETRY`, 2: ERROR recoveries allowed per run; range 0..15.

- `clk`  in  1  clock
- `nrst`  in  1  reset, asynchronous, active-low
- `start`  in  1  run request; sampled only when `busy`=0
- `loops`  in  CNT_W  loop count, sampled with `start`
- `force_err`  in  1  sampled with `start`; first step of the run deliberately provokes ERROR
- `obs`  in  3  FSM outputs {o1,o2,err}
- `i1`, `i2`  out  1 each  registered FSM inputs
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse at end of run (success or fail)
- `fail`  out  1  run aborted; sticky until next accepted `start`
- `loops_done`  out  CNT_W  loops completed in current/last run
- `retries`  out  4  ERROR recoveries used in current/last run

## Operation
- Observed codes on `obs`: IDLE=000, S1=100, S2=010, ERROR=111. Any other value is a mismatch.
- Step table, given as drive (i1,i2) → expect / park (i1,i2):
  - step0: drive (1,1) → S1 / park (0,0)
  - step1: drive (1,1) → S2 / park (0,1)
  - step2: drive (1,0) → IDLE / park (0,0)
  - With `force_err` latched, the first step0 of the run drives (1,0) instead, which provokes ERROR. This substitution happens once per run.
- Controller states and transitions:
  - C_IDLE: waits for `start`.
  - C_DRIVE: drive values are present for exactly one cycle.
  - C_CHECK: park values are present; `obs` is compared at the end of this cycle.
  - C_RECOVER: drives (0,0) for one cycle.
  - C_RCHK: parks (0,0) and expects IDLE.
- C_CHECK outcome:
  - Match: advance to the next step. A successful step2 increments `loops_done`; when `loops_done` reaches `loops`, end the run successfully.
  - `obs`=ERROR with `retries`<MAX_RETRY: increment `retries`, go to C_RECOVER.
  - `obs`=ERROR with `retries`=MAX_RETRY, or any other mismatch: end the run with `fail`=1.
- C_RCHK outcome:
  - IDLE: restart the current loop at step0. `loops_done` is unchanged.
  - Otherwise: end the run with `fail`=1.
- End of run: `busy`←0, `done` pulses, `i1`/`i2`←(0,0), counters hold their values.
- `loops`=0: `done` pulses one cycle after `start` is accepted, `fail`=0, and `i1`/`i2` never leave (0,0).
- `start` while `busy`=1 is ignored.
- Accepting `start` clears `fail`, `loops_done` and `retries`.

## Timing
- Reset values: `i1`=0, `i2`=0, `busy`=0, `done`=0, `fail`=0, `loops_done`=0, `retries`=0. Controller state is C_IDLE.
- Reset asserted mid-run returns to reset values immediately; no `done` pulse is generated.
- Edge numbering: `start` is sampled at edge 0, and from that edge `busy`=1 and step0 drive values are on `i1`/`i2`.
- The FSM consumes drive values at edge 1. Park values are on the outputs from edge 1, and `obs` is compared at edge 2.
- Each step takes 2 edges, so one loop takes 6 edges. A clean run of N loops ends at edge 6N, where `done`=1 for one cycle and `busy`=0.
- Each recovery adds 2 edges and repeats any partially completed loop.
- The `obs` comparison and the next drive/park update happen on the same edge.

## Structure
- Shared package `sm_ctrl_pkg` holds:
  - observed-code constants (IDLE/S1/S2/ERROR)
  - controller state encoding
  - step-table function: step index → drive, park and expected code
- No sub-module. The verification top instantiates `sm_seq_ctrl` together with the target FSM, with `obs` wired to {o1,o2,err} and the FSM's `i1`/`i2` driven from the controller.

## Test plan
- `loops`=3, `force_err`=0, real FSM → `done` at edge 18, `fail`=0, `loops_done`=3, `retries`=0. The FSM visits S1, S2, IDLE three times.
- `loops`=1, `force_err`=1 → ERROR seen at edge 2, `retries`=1, IDLE seen at edge 4, `done` at edge 10, `fail`=0, `loops_done`=1.
- `loops`=2, `force_err`=1, MAX_RETRY=0 → `done` and `fail`=1 at edge 2, `loops_done`=0, `i1`/`i2`=(0,0) afterwards.
- `obs` forced to 000 with `loops`=1 → mismatch at edge 2, `fail`=1, `done` pulse. A following `start` clears `fail` at its sampling edge.
- `loops`=0 → `done` at edge 1, `i1`/`i2` remain 0. A second `start` pulse applied while `busy`=1 during a `loops`=4 run is ignored: the run still ends at edge 24.
- `nrst` asserted at edge 7 of a `loops`=5 run → all outputs return to reset values at once, no `done` pulse. A fresh `start` after reset completes normally.
